key_debounce: RTL
=================

# key_debounce

Debounced push-button front end for the LED demo. It takes one raw, asynchronous, active-low board key, synchronises and debounces it, and produces a clean level plus single-cycle press, release and long-press pulses. The block sits directly upstream of the LED controller in the 25 MHz domain, where those pulses drive mode and pattern selection.

## Interface
- `DEBOUNCE_CYC`, default 500000: stable-input cycles required to accept a change (20 ms at 25 MHz); must be ≥1.
- `LONG_CYC`, default 25000000: held cycles after an accepted press before `key_long` fires (1 s at 25 MHz); must be ≥1.
- `clk` input 1: system clock (`clk_25m` in the top level).
- `rst` input 1: synchronous, active-high reset.
- `key_n` input 1: raw key pin, active low, asynchronous, bouncing.
- `key_level` output 1: debounced key state; 1 means pressed.
- `key_press` output 1: one-cycle pulse when a press is accepted.
- `key_release` output 1: one-cycle pulse when a release is accepted.
- `key_long` output 1: one-cycle pulse once per press, after `LONG_CYC` held cycles.

## Operation
- **Synchroniser:** 2-FF synchroniser on `key_n`. Both flops reset to 1 (released). The FSM sees only the second flop (`key_s`).
- **FSM states:** IDLE, PRESS_WAIT, HELD, REL_WAIT. Reset state is IDLE.
- **IDLE:** on `key_s`=0, go to PRESS_WAIT and set `cnt`=0.
- **PRESS_WAIT:**
  - `key_s`=1 is a bounce: return to IDLE with no outputs.
  - Otherwise increment `cnt`.
  - At `cnt`==`DEBOUNCE_CYC`-1 with `key_s`=0: go to HELD, pulse `key_press`, set `key_level`=1, clear `long_cnt` and `long_done`.
- **HELD:**
  - `key_s`=1: go to REL_WAIT and set `cnt`=0.
  - Otherwise, while `long_done`=0, increment `long_cnt`.
  - At `long_cnt`==`LONG_CYC`-1: pulse `key_long` and set `long_done`.
- **REL_WAIT:**
  - `key_s`=0 is a bounce: return to HELD. `long_cnt` is kept, not cleared.
  - Otherwise increment `cnt`.
  - At `cnt`==`DEBOUNCE_CYC`-1 with `key_s`=1: go to IDLE, pulse `key_release`, set `key_level`=0.
- **Counter widths:** `cnt` is `$clog2(DEBOUNCE_CYC+1)` bits; `long_cnt` is `$clog2(LONG_CYC+1)` bits. Neither counter can wrap: `cnt` is bounded by the compare, and `long_cnt` stops once `long_done` is set.
- **Exclusivity:** `key_press`, `key_release` and `key_long` are never high in the same cycle.
- **Reset mid-operation:** return to IDLE with all outputs 0. If the key is still held after reset, a fresh full debounce runs and `key_press` fires again.

## Timing
- **Reset values:** `key_level`, `key_press`, `key_release` and `key_long` are all 0.
- **Registered outputs:** all outputs come from flops; there is no combinational path from `key_n`.
- **Edge numbering:** edge 0 is the first edge at which `key_n` is sampled low; D = `DEBOUNCE_CYC`, L = `LONG_CYC`.
  - Edge 2: the FSM enters PRESS_WAIT.
  - Edge D+2: `key_press` and `key_level` rise; `key_press` is high for exactly one cycle.
  - Edge D+L+2: `key_long` is high for one cycle, provided the key is held without bounce.
- **Release:** symmetric to press. With edge 0 as the first high sample, `key_release` rises and `key_level` falls at edge D+2.
- **Bounce window:** any bounce inside the window restarts the debounce from the state it returned to. A pulse shorter than D+1 cycles never reaches the outputs.

## Configuration
- **Macro:** `KEY_LONG_PRESS_EN`.
- **Defined:** `long_cnt`, `long_done` and the `key_long` logic are built as described above.
- **Undefined:** `key_long` is tied to 0 and `long_cnt`/`long_done` are not instantiated. `LONG_CYC` stays in the interface but is ignored. All other behaviour is identical.

## Structure
- **Package `key_pkg`:** state enum typedef (IDLE, PRESS_WAIT, HELD, REL_WAIT) and the default cycle-count constants.
- **Sub-module `sync_2ff`:** generic 2-flop synchroniser with a reset-value parameter (set to 1 here). It will be reused by other key and UART inputs.

## Test plan
Benches use D=4, L=10, with key_n=1 held from reset unless stated.
- **Clean press:** drive `key_n` to 0 and hold → `key_press` is a single pulse at edge 6, `key_level`=1 from edge 6, `key_long` pulses at edge 16 and never again while held.
- **Bounce on press:** drive `key_n` to 0 for 3 cycles, 1 for 1 cycle, then 0 and hold → no pulse from the first burst; `key_press` fires 6 edges after the final falling sample.
- **Release:** after a press is accepted, drive `key_n` to 1 and hold → `key_release` pulses and `key_level` falls at edge 6; a 2-cycle high glitch while held produces no release and does not restart `long_cnt`.
- **Short press:** press for 10 cycles, then release → `key_press` and `key_release` once each, no `key_long`.
- **Reset mid-hold:** assert `rst` for 1 cycle at edge 8 of a hold → all outputs 0 immediately after; with the key still held, `key_press` fires again D+2 edges after the first low sample following reset.
- **Macro off:** build without `KEY_LONG_PRESS_EN` and hold the key for 30 cycles → `key_long` stays 0 throughout; press and release timing is unchanged.

Source files
------------

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and default cycle counts for the key debouncer
package key_pkg;

    // Debouncer FSM states
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } key_state_t;

    // 20 ms and 1 s at 25 MHz
    localparam int DEBOUNCE_CYC_DEF = 500000;
    localparam int LONG_CYC_DEF     = 25000000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser with configurable reset value
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; only q is safe to use in the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - key debouncer with press/release/long pulses; long press built when KEY_LONG_PRESS_EN is defined
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int LONG_CYC     = LONG_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    // Both counts must be at least one cycle; LONG_CYC is checked even when long press is not built
    if (DEBOUNCE_CYC < 1 || LONG_CYC < 1) begin : g_param_check
        $error("key_debounce: DEBOUNCE_CYC and LONG_CYC must be >= 1");
    end

    logic             key_s;
    key_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Key idles high (released), so the synchroniser resets to 1
    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_n),
        .q   (key_s)
    );

`ifdef KEY_LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_CYC + 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);

    logic [LONG_W-1:0] long_cnt;
    logic              long_done;
`else
    assign key_long = 1'b0;
`endif

    // Debounce FSM with registered level and single-cycle event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            long_cnt    <= '0;
            long_done   <= 1'b0;
            key_long    <= 1'b0;
`endif
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            key_long    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!key_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (key_s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= HELD;
                        key_press <= 1'b1;
                        key_level <= 1'b1;
`ifdef KEY_LONG_PRESS_EN
                        long_cnt  <= '0;
                        long_done <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (key_s) begin
                        state <= REL_WAIT;
                        cnt   <= '0;
                    end
`ifdef KEY_LONG_PRESS_EN
                    // long_cnt freezes once long_done is set, so it never wraps
                    else if (!long_done) begin
                        if (long_cnt == LONG_LAST) begin
                            key_long  <= 1'b1;
                            long_done <= 1'b1;
                        end else begin
                            long_cnt <= long_cnt + 1'b1;
                        end
                    end
`endif
                end
                REL_WAIT: begin
                    // A bounce back to HELD keeps the long-press count running
                    if (!key_s) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state       <= IDLE;
                        key_release <= 1'b1;
                        key_level   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
